// File: rtl/fold_pkg.sv
// Shared definitions for the folded 5-tap FIR front end.
//   DEF_WIDTH / DEF_FOLD / DEF_DEPTH : default sample width, folding factor, FIFO depth
//   PHASE_W                          : width of the fold phase for the default FOLD
//   sample_t                         : signed sample type at the default width
//   M1..M5                           : filter coefficients shared with the datapath
package fold_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_FOLD  = 2;
   localparam int DEF_DEPTH = 4;
   localparam int PHASE_W   = $clog2(DEF_FOLD);

   typedef logic signed [DEF_WIDTH-1:0] sample_t;

   localparam sample_t M1 = -8'sd64;
   localparam sample_t M2 =  8'sd127;
   localparam sample_t M3 =  8'sd126;
   localparam sample_t M4 = -8'sd127;
   localparam sample_t M5 = -8'sd126;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read.
//   clk, rst_n  : clock, async active-low reset (clears pointers and count)
//   push, wdata : write wdata when push and not full
//   pop         : drop the head when pop and not empty
//   rdata       : current head entry
//   count       : number of stored entries, 0..DEPTH
//   full, empty : count == DEPTH / count == 0
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage is not reset; an empty count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fold_sample_feeder.sv
// Input stage for the folded FIR: buffers samples and presents each one for
// FOLD cycles, inserting counted zero bubbles when the buffer runs dry.
//   clk, rst_n          : clock, async active-low reset
//   in_data, in_valid   : upstream sample and its valid
//   in_ready            : buffer has room (combinational from registered state)
//   out_sample          : sample for the current slot, 0 for a bubble
//   out_valid           : out_sample is a real sample
//   out_phase           : fold phase 0..FOLD-1
//   underflow_cnt       : bubble slots seen, saturating at 255
module fold_sample_feeder
   import fold_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FOLD  = DEF_FOLD,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_sample,
   output logic                    out_valid,
   output logic [$clog2(FOLD)-1:0] out_phase,
   output logic [7:0]              underflow_cnt
);
   localparam int PW = $clog2(FOLD);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0]    phase_q;
   logic             slot_end;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   assign slot_end  = (phase_q == PW'(FOLD - 1));
   assign in_ready  = rst_n && !fifo_full;
   assign push      = in_valid && in_ready;
   // The head is sampled before this edge's push lands, so a sample pushed
   // on a boundary edge waits for the next slot.
   assign pop       = slot_end && !fifo_empty;
   assign out_phase = phase_q;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else if (slot_end) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sample    <= '0;
         out_valid     <= 1'b0;
         underflow_cnt <= '0;
      end else if (slot_end) begin
         if (pop) begin
            out_sample <= head;
            out_valid  <= 1'b1;
         end else begin
            out_sample <= '0;
            out_valid  <= 1'b0;
            if (fifo_count == '0 && underflow_cnt != 8'hFF)
               underflow_cnt <= underflow_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_fold_sample_feeder.sv
module tb_fold_sample_feeder;
   localparam int W = 8;
   localparam int F = 2;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out_sample;
   logic         out_valid;
   logic [$clog2(F)-1:0] out_phase;
   logic [7:0]   underflow_cnt;

   fold_sample_feeder #(.WIDTH(W), .FOLD(F), .DEPTH(D)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_sample    (out_sample),
      .out_valid     (out_valid),
      .out_phase     (out_phase),
      .underflow_cnt (underflow_cnt)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference: queue of waiting samples, cycles elapsed since reset release,
   // and the value/valid/bubble count currently shown to the filter.
   int q[$];
   int cyc;
   int exp_sample;
   int exp_valid;
   int exp_uf;
   bit in_rst;
   bit last_acc;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outs();
      chk("out_sample", $signed(out_sample), exp_sample);
      chk("out_valid", {31'd0, out_valid}, exp_valid);
      chk("out_phase", {31'd0, out_phase}, cyc % F);
      chk("underflow_cnt", {24'd0, underflow_cnt}, exp_uf);
      chk("in_ready", {31'd0, in_ready}, (!in_rst && q.size() < D) ? 1 : 0);
   endtask

   task automatic model_reset();
      q.delete();
      cyc        = 0;
      exp_sample = 0;
      exp_valid  = 0;
      exp_uf     = 0;
   endtask

   // One clock: offer (v, d), advance the reference at the edge, check after.
   task automatic step(input bit v, input int d);
      bit   acc;
      logic [7:0] b;
      b        = d[7:0];
      in_valid = v;
      in_data  = b;
      acc      = v && (q.size() < D);
      last_acc = acc;
      @(posedge clk);
      if (cyc % F == F - 1) begin
         if (q.size() > 0) begin
            exp_sample = q.pop_front();
            exp_valid  = 1;
         end else begin
            exp_sample = 0;
            exp_valid  = 0;
            if (exp_uf < 255) exp_uf++;
         end
      end
      if (acc) q.push_back(int'($signed(b)));
      cyc++;
      #1;
      in_valid = 1'b0;
      check_outs();
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      in_rst = 1'b1;
      model_reset();
      #1;
      check_outs();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_outs();
      end
      rst_n  = 1'b1;
      in_rst = 1'b0;
      #1;
      check_outs();
   endtask

   initial begin
      int nxt;
      int guard;
      bit saw_stall;

      in_rst = 1'b0;
      model_reset();
      #1;
      do_reset();

      for (int i = 0; i < 6; i++) step(0, 0);

      // single sample pushed at phase 0
      while (cyc % F != 0) step(0, 0);
      step(1, -45);
      for (int i = 0; i < 5; i++) step(0, 0);

      // single sample pushed at phase 1 (one bubble first)
      while (cyc % F != 1) step(0, 0);
      step(1, 100);
      for (int i = 0; i < 6; i++) step(0, 0);

      // back-to-back offers 1..8; data advances only on acceptance
      nxt = 1;
      guard = 0;
      saw_stall = 0;
      while (nxt <= 8 && guard < 200) begin
         if (!in_ready) saw_stall = 1;
         step(1, nxt);
         if (last_acc) nxt++;
         guard++;
      end
      chk("burst_all_accepted", nxt, 9);
      chk("burst_backpressure", {31'd0, saw_stall}, 1);
      for (int i = 0; i < 20; i++) step(0, 0);

      // long idle: bubble counter saturates
      for (int i = 0; i < 600; i++) step(0, 0);
      chk("uf_saturated", {24'd0, underflow_cnt}, 255);
      chk("uf_idle_sample", $signed(out_sample), 0);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 99) < 60), int'($urandom_range(0, 255)));

      // reset mid-slot with samples queued
      for (int i = 0; i < 6; i++) step(0, 0);
      guard = 0;
      while (q.size() < 3 && guard < 20) begin
         step(1, 50 + guard);
         guard++;
      end
      chk("queued_before_reset", q.size(), 3);
      do_reset();
      for (int i = 0; i < 12; i++) step(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fold_sample_feeder.md
# fold_sample_feeder

Upstream input stage for the folded 5-tap FIR datapath. It accepts 8-bit signed samples over a valid/ready handshake and buffers them in a small FIFO. Each sample is presented to the folded filter as a stable input for exactly FOLD consecutive clock cycles, with the current fold phase alongside it. When no sample is available it inserts zero-valued bubble slots, so the free-running filter always sees a defined input, and it counts those bubbles.

## Interface
Parameters:
- WIDTH, 8, sample width (signed two's complement)
- FOLD, 2, clock cycles per sample slot (folding factor, ≥2)
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_data  in  WIDTH  signed input sample
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  feeder can accept a sample this cycle
- out_sample  out  WIDTH  signed sample to the folded filter, held constant for a full slot
- out_valid  out  1  out_sample is a real sample (0 = bubble)
- out_phase  out  $clog2(FOLD)  fold phase, 0..FOLD-1
- underflow_cnt  out  8  count of bubble slots, saturating at 255

## Operation
- Push: a sample is written when in_valid && in_ready.
- in_ready = rst_n && (count != DEPTH). It is derived from registered state only and has no combinational path from in_valid.
- Phase counter:
  - free-runs 0,1,…,FOLD-1,0,… starting at 0 after reset release;
  - a slot boundary is the rising edge at which out_phase == FOLD-1;
  - the phase wraps to 0 on that same edge.
- At each slot boundary:
  - FIFO non-empty: pop the head into out_sample and set out_valid=1.
  - FIFO empty: out_sample=0, out_valid=0, underflow_cnt += 1 (held at 255 once reached).
- No bypass. A sample pushed on a boundary edge is not eligible for that boundary.
- Simultaneous push and pop on one edge: both occur and count is unchanged.
- With count == DEPTH, in_ready=0. A pop at a boundary raises in_ready in the following cycle.
- Samples are never dropped, duplicated or reordered. No arithmetic is performed; the value passes through bit-exact.
- Reset (any time, including mid-slot):
  - FIFO contents discarded and count=0; phase=0;
  - out_sample=0, out_valid=0, underflow_cnt=0;
  - in_ready=0 while rst_n is low.

## Timing
- Reset values: out_sample 0, out_valid 0, out_phase 0, underflow_cnt 0, in_ready 0. in_ready rises combinationally when rst_n deasserts.
- out_sample and out_valid change only at slot boundaries, so they are stable for exactly FOLD cycles. They are valid during out_phase 0..FOLD-1 of the slot.
- Latency from push edge to out_sample update, FIFO initially empty:
  - push at phase p < FOLD-1: FOLD-1-p edges;
  - push at phase FOLD-1: FOLD edges.
- Sustained throughput: one sample per FOLD cycles.
- All outputs are registered except in_ready.

## Structure
- Shared package fold_pkg: WIDTH and FOLD defaults, the phase-width constant, a sample_t signed typedef, and the coefficient constants shared with the filter (m1=-64, m2=127, m3=126, m4=-127, m5=-126).
- Sub-module sync_fifo (WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata (head, combinational), count, full, empty;
  - pointer wrap modulo DEPTH;
  - count width $clog2(DEPTH)+1.
- Top level holds the phase counter, slot register and underflow counter.

## Test plan
(FOLD=2, DEPTH=4)
- Reset → all outputs 0 and in_ready=0. After release: in_ready=1, out_phase toggles 0,1,0,…, out_valid=0, underflow_cnt increments every 2 cycles.
- Push -45 at phase 0 → out_sample=-45 and out_valid=1 after the next edge, held for 2 cycles, then bubble (0, out_valid=0).
- Push 100 at phase 1 → one bubble slot first; 100 appears 2 edges later.
- in_valid held high with samples 1..8, one offered per cycle (in_data advances only on accepted pushes) → in_ready drops when count reaches 4. out_sample sequence is 1,2,…,8 with each value held 2 cycles, and nothing is lost.
- No input for 600 cycles → underflow_cnt saturates at 255 and stays there. out_sample remains 0.
- Reset asserted mid-slot with 3 samples queued → outputs return to 0 immediately and the queued samples never appear after release.
